// File: rtl/add_arbiter_ctrl_if.sv
// Bus between the shared-adder controller, its two requesters, the external
// ripple-carry adder and the result consumer.
interface add_arbiter_ctrl_if #(
    parameter int unsigned N = 8
);
    logic         req0;
    logic         req1;
    logic [N-1:0] a0;
    logic [N-1:0] b0;
    logic         cin0;
    logic [N-1:0] a1;
    logic [N-1:0] b1;
    logic         cin1;
    logic         gnt0;
    logic         gnt1;
    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic         add_cin;
    logic [N-1:0] add_sum;
    logic         add_cout;
    logic         res_valid;
    logic         res_ready;
    logic         res_id;
    logic [N-1:0] res_sum;
    logic         res_cout;

    modport master (
        output req0, req1, a0, b0, cin0, a1, b1, cin1,
        output add_sum, add_cout, res_ready,
        input  gnt0, gnt1, add_a, add_b, add_cin,
        input  res_valid, res_id, res_sum, res_cout
    );

    modport slave (
        input  req0, req1, a0, b0, cin0, a1, b1, cin1,
        input  add_sum, add_cout, res_ready,
        output gnt0, gnt1, add_a, add_b, add_cin,
        output res_valid, res_id, res_sum, res_cout
    );
endinterface

// File: rtl/add_arbiter_ctrl.sv
// Round-robin sharing of one external combinational adder between two
// requesters; operands are held for SETTLE_CYC cycles before the sum is captured.
module add_arbiter_ctrl #(
    parameter int unsigned N          = 8,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    add_arbiter_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC - 1);

    state_t       state_q;
    logic [N-1:0] opa_q;
    logic [N-1:0] opb_q;
    logic         opc_q;
    logic         id_q;
    logic         last_q;
    logic [3:0]   cnt_q;
    logic [N-1:0] sum_q;
    logic         cout_q;
    logic         valid_q;

    logic         sel1_d;
    logic         gnt_any_d;

    // Requester 1 wins alone, or on a tie when requester 0 was granted last.
    // Grants are gated by rst_n so they stay low while reset is held.
    always_comb begin
        sel1_d    = bus.req1 & (~bus.req0 | ~last_q);
        gnt_any_d = rst_n & (state_q == IDLE) & (bus.req0 | bus.req1);
    end

    assign bus.gnt0      = gnt_any_d & ~sel1_d;
    assign bus.gnt1      = gnt_any_d & sel1_d;
    assign bus.add_a     = opa_q;
    assign bus.add_b     = opb_q;
    assign bus.add_cin   = opc_q;
    assign bus.res_valid = valid_q;
    assign bus.res_id    = id_q;
    assign bus.res_sum   = sum_q;
    assign bus.res_cout  = cout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            opc_q   <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_any_d) begin
                        opa_q   <= sel1_d ? bus.a1   : bus.a0;
                        opb_q   <= sel1_d ? bus.b1   : bus.b0;
                        opc_q   <= sel1_d ? bus.cin1 : bus.cin0;
                        id_q    <= sel1_d;
                        last_q  <= sel1_d;
                        cnt_q   <= CNT_LOAD;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        sum_q   <= bus.add_sum;
                        cout_q  <= bus.add_cout;
                        valid_q <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.res_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_add_arbiter_ctrl.sv
// Bench for add_arbiter_ctrl: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_add_arbiter_ctrl;
    localparam int unsigned N = 8;
    localparam int unsigned S = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    add_arbiter_ctrl_if #(.N(N)) bus ();

    add_arbiter_ctrl #(.N(N), .SETTLE_CYC(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // External adder, purely combinational.
    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{N{1'b0}}, bus.add_cin};

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           cyc = 0;
    bit           m_busy = 1'b0;
    bit           m_last = 1'b1;
    int           m_gcyc = 0;
    bit           m_id = 1'b0;
    logic [N-1:0] m_a = '0;
    logic [N-1:0] m_b = '0;
    logic         m_cin = 1'b0;
    logic [N:0]   m_full = '0;
    bit           m_win;
    bit           m_gnt;
    bit           m_valid;
    int           g_id[$];
    int           g_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_gnt0", 32'(bus.gnt0), 0);
            chk("rst_gnt1", 32'(bus.gnt1), 0);
            chk("rst_add_a", 32'(bus.add_a), 0);
            chk("rst_add_b", 32'(bus.add_b), 0);
            chk("rst_add_cin", 32'(bus.add_cin), 0);
            chk("rst_valid", 32'(bus.res_valid), 0);
            chk("rst_id", 32'(bus.res_id), 0);
            chk("rst_sum", 32'(bus.res_sum), 0);
            chk("rst_cout", 32'(bus.res_cout), 0);
            m_busy = 1'b0; m_last = 1'b1; m_a = '0; m_b = '0; m_cin = 1'b0;
        end else begin
            m_valid = m_busy && (cyc >= m_gcyc + int'(S) + 1);
            m_gnt   = !m_busy && (bus.req0 || bus.req1);
            m_win   = (bus.req0 && bus.req1) ? !m_last : bus.req1;
            chk("gnt0", 32'(bus.gnt0), 32'(m_gnt && !m_win));
            chk("gnt1", 32'(bus.gnt1), 32'(m_gnt && m_win));
            chk("gnt_excl", 32'(bus.gnt0 & bus.gnt1), 0);
            chk("add_a", 32'(bus.add_a), 32'(m_a));
            chk("add_b", 32'(bus.add_b), 32'(m_b));
            chk("add_cin", 32'(bus.add_cin), 32'(m_cin));
            chk("res_valid", 32'(bus.res_valid), 32'(m_valid));
            if (m_valid) begin
                chk("res_id", 32'(bus.res_id), 32'(m_id));
                chk("res_sum", 32'(bus.res_sum), 32'(m_full[N-1:0]));
                chk("res_cout", 32'(bus.res_cout), 32'(m_full[N]));
            end
            if (m_valid && bus.res_ready) m_busy = 1'b0;
            if (m_gnt) begin
                m_a    = m_win ? bus.a1 : bus.a0;
                m_b    = m_win ? bus.b1 : bus.b0;
                m_cin  = m_win ? bus.cin1 : bus.cin0;
                m_full = {1'b0, m_a} + {1'b0, m_b} + {{N{1'b0}}, m_cin};
                m_id   = m_win;
                m_last = m_win;
                m_busy = 1'b1;
                m_gcyc = cyc;
                g_id.push_back(int'(m_win));
                g_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_gnt(output bit ok, output bit who);
        ok = 1'b0; who = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus.gnt0 || bus.gnt1) begin
                ok = 1'b1; who = bus.gnt1;
                break;
            end
        end
        chk("gnt_timeout", 32'(ok), 1);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                lat = t;
                break;
            end
        end
        chk("valid_timeout", 32'(lat != 0), 1);
    endtask

    task automatic do_op(input bit id, input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [7:0] es, input logic ec);
        bit ok, who;
        int lat;
        if (id) begin bus.a1 = a; bus.b1 = b; bus.cin1 = cin; bus.req1 = 1'b1; end
        else    begin bus.a0 = a; bus.b0 = b; bus.cin0 = cin; bus.req0 = 1'b1; end
        wait_gnt(ok, who);
        if (!ok) return;
        chk("op_who", 32'(who), 32'(id));
        @(posedge clk); #1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        wait_valid(lat);
        chk("op_latency", 32'(lat), 32'(S + 1));
        chk("op_sum", 32'(bus.res_sum), 32'(es));
        chk("op_cout", 32'(bus.res_cout), 32'(ec));
        chk("op_id", 32'(bus.res_id), 32'(id));
        @(posedge clk); #1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        bit ok, who;
        int lat, vcnt;
        logic [7:0] opa [4];
        logic [7:0] opb [4];
        opa[0] = 8'h12; opb[0] = 8'h34;
        opa[1] = 8'hF0; opb[1] = 8'h20;
        opa[2] = 8'h80; opb[2] = 8'h80;
        opa[3] = 8'h01; opb[3] = 8'hFE;

        bus.req0 = 0; bus.req1 = 0; bus.a0 = '0; bus.b0 = '0; bus.cin0 = 0;
        bus.a1 = '0; bus.b1 = '0; bus.cin1 = 0; bus.res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(1'b0, 8'h55, 8'h33, 1'b0, 8'h88, 1'b0);
        do_op(1'b1, 8'hAC, 8'hB3, 1'b1, 8'h60, 1'b1);
        do_op(1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
        do_op(1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        do_op(1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

        // Arbitration: both requesters held from reset, two operations each.
        rst_n = 1'b0;
        bus.a0 = opa[0]; bus.b0 = opb[0]; bus.cin0 = 0;
        bus.a1 = opa[1]; bus.b1 = opb[1]; bus.cin1 = 1;
        bus.req0 = 1; bus.req1 = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        g_id.delete(); g_cyc.delete();
        for (int k = 0; k < 4; k++) begin
            wait_gnt(ok, who);
            @(posedge clk); #1;
            if (k == 3) begin
                bus.req0 = 0; bus.req1 = 0;
            end else if (who) begin
                bus.a1 = opa[3]; bus.b1 = opb[3];
            end else begin
                bus.a0 = opa[2]; bus.b0 = opb[2]; bus.cin0 = 1;
            end
        end
        wait_valid(lat);
        @(posedge clk); #1;
        chk("arb_count", 32'(g_id.size()), 4);
        if (g_id.size() == 4) begin
            for (int k = 0; k < 4; k++) chk("arb_order", 32'(g_id[k]), 32'(k % 2));
            for (int k = 1; k < 4; k++) chk("arb_spacing", 32'(g_cyc[k] - g_cyc[k-1]), 4);
        end

        // Backpressure with a pending req1.
        bus.res_ready = 0;
        bus.a0 = 8'h10; bus.b0 = 8'h20; bus.cin0 = 0; bus.req0 = 1;
        wait_gnt(ok, who);
        @(posedge clk); #1;
        bus.req0 = 0; bus.a1 = 8'h07; bus.b1 = 8'h09; bus.cin1 = 0; bus.req1 = 1;
        wait_valid(lat);
        for (int k = 0; k < 5; k++) begin
            if (k != 0) @(negedge clk);
            chk("bp_valid", 32'(bus.res_valid), 1);
            chk("bp_sum", 32'(bus.res_sum), 32'h30);
            chk("bp_id", 32'(bus.res_id), 0);
            chk("bp_gnt1", 32'(bus.gnt1), 0);
        end
        @(posedge clk); #1 bus.res_ready = 1;
        @(negedge clk);
        chk("bp_hs_gnt1", 32'(bus.gnt1), 0);
        @(negedge clk);
        chk("bp_next_gnt1", 32'(bus.gnt1), 1);
        @(posedge clk); #1 bus.req1 = 0;
        wait_valid(lat);
        chk("bp_r1_sum", 32'(bus.res_sum), 32'h10);
        @(posedge clk); #1;

        // Reset during SETTLE after a req0 grant.
        bus.a0 = 8'h01; bus.b0 = 8'h02; bus.cin0 = 0; bus.req0 = 1;
        wait_gnt(ok, who);
        @(posedge clk); #1;
        bus.req0 = 0;
        rst_n = 0;
        #1;
        chk("mr_add_a", 32'(bus.add_a), 0);
        chk("mr_add_b", 32'(bus.add_b), 0);
        chk("mr_valid", 32'(bus.res_valid), 0);
        chk("mr_sum", 32'(bus.res_sum), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        vcnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.res_valid) vcnt++;
        end
        chk("mr_no_valid", 32'(vcnt), 0);
        @(posedge clk); #1;
        bus.a1 = 8'h03; bus.b1 = 8'h04; bus.req0 = 1; bus.req1 = 1;
        wait_gnt(ok, who);
        chk("mr_tie_gnt0", 32'(bus.gnt0), 1);
        @(posedge clk); #1;
        bus.req0 = 0; bus.req1 = 0;
        wait_valid(lat);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/add_arbiter_ctrl.md
# add_arbiter_ctrl

Shares one combinational N-bit ripple-carry adder (N_bit_adder) between two requesters. A round-robin arbiter grants one requester at a time and registers its operands. The block drives the external adder's inputs for a programmable number of settle cycles to cover ripple delay, then captures sum/carry and returns the result tagged with the requester ID over a valid/ready handshake.

## Interface
- N, 8, operand/sum width; must match the adder instance.
- SETTLE_CYC, 2, cycles adder inputs are held stable before capture; legal range 1..15.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0 / req1  in  1  request from requester 0 / 1; held high until granted.
- a0, b0 / a1, b1  in  N  operands of requester 0 / 1.
- cin0 / cin1  in  1  carry-in of requester 0 / 1.
- gnt0 / gnt1  out  1  one-cycle grant; operands are sampled on the same rising edge.
- add_a, add_b  out  N  operands to the adder.
- add_cin  out  1  carry-in to the adder.
- add_sum  in  N  adder sum.
- add_cout  in  1  adder carry-out.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_id  out  1  requester that owns the result (0/1).
- res_sum  out  N  captured sum.
- res_cout  out  1  captured carry-out.

## Operation
- FSM states: IDLE, SETTLE, RESP.
- **IDLE**
  - If any req is high, select one. A single requester wins directly. If both request, the one not granted last wins.
  - gnt_sel is asserted combinationally in this cycle.
  - On the edge: capture a/b/cin into the operand registers, set id, update last_gnt, load cnt = SETTLE_CYC-1, go to SETTLE.
  - With no request, stay in IDLE.
- **SETTLE**
  - add_a/add_b/add_cin come from the operand registers.
  - If cnt == 0, capture add_sum/add_cout into res_sum/res_cout and go to RESP. Otherwise decrement cnt.
- **RESP**
  - res_valid = 1.
  - If res_ready is high, go to IDLE on the edge. Otherwise hold, with all res_* stable.
- Gnt signals are low in SETTLE and RESP. Requests made while busy wait and are never lost or queued twice.
- gnt0 and gnt1 are never high together.
- add_* always reflect the operand registers in every state; they change only on a grant edge.
- Arithmetic: {res_cout,res_sum} = a + b + cin, modulo 2^(N+1). No saturation.
- Reset (asynchronous, any state)
  - State returns to IDLE; any in-flight operation is aborted with no result produced.
  - Every output is 0: gnt0, gnt1, add_a, add_b, add_cin, res_valid, res_id, res_sum, res_cout.
  - last_gnt = 1, so req0 wins the first tie after reset.
  - cnt = 0.
- A req dropped before it is granted is simply not serviced.

## Timing
- Grant edge is T0. SETTLE spans cycles T0+1 .. T0+SETTLE_CYC.
- Capture happens on edge T0+SETTLE_CYC. res_valid is high from that edge.
- With res_ready held high, RESP lasts 1 cycle and IDLE lasts 1 cycle.
- Peak throughput: one operation per SETTLE_CYC+2 cycles.
- Earliest next grant: the cycle after the handshake cycle (res_valid & res_ready).
- Back-to-back ties alternate 0,1,0,1.
- A single requester may be granted consecutively.

## Test plan
- **Basic add:** N=8, SETTLE_CYC=2; req0 with a0=0x55, b0=0x33, cin0=0.
  - gnt0 pulses once.
  - res_valid rises 2 cycles after the grant edge with res_sum=0x88, res_cout=0, res_id=0.
- **Carry-out:** req1 with a1=0xAC, b1=0xB3, cin1=1 -> res_sum=0x60, res_cout=1, res_id=1.
- **Wrap-around:** a0=0xFF, b0=0x00, cin0=1 -> res_sum=0x00, res_cout=1.
  - Also a0=0xFF, b0=0xFF, cin0=1 -> 0xFF, cout=1.
- **Arbitration:** both req held high from reset with 4 queued operations.
  - Grant order is 0,1,0,1; each res_id matches.
  - gnt0/gnt1 are never high together.
  - Grants are spaced exactly 4 cycles apart.
- **Backpressure:** hold res_ready low for 5 cycles during RESP.
  - res_valid and res_* stay stable.
  - No gnt is issued and the pending req1 stays ungranted.
  - Once res_ready rises, req1 is granted the cycle after the handshake.
- **Reset mid-operation:** assert rst_n low during SETTLE.
  - All outputs go to 0 immediately.
  - No res_valid follows.
  - After release, a tie grants req0 first.
